drum_sweep_scheduler: RTL and testbench

Central sequencer for the column-parallel drum-node array. Drives the shared row index, M10K addresses, write enables and phase strobes that all column datapaths consume in lockstep. Runs the one-time grid-init sweep, then repeats per-time-step row sweeps. Captures the tap-node amplitude once per step and hands it to the audio path over a valid/ready handshake, stalling the grid when audio has not consumed the previous sample.

---
 rtl/drum_sweep_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_drum_sweep_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/drum_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : drum_sweep_scheduler
// Purpose  : Central sequencer for the column-parallel drum-node array. Runs
//            the one-time grid-init sweep, then repeats per-time-step row
//            sweeps (SETUP/WAIT/LOAD/WRITE per row), captures the tap-row
//            amplitude once per step and hands it to the audio path over a
//            valid/ready handshake, stalling the grid while audio is behind.
// Ports    : clk_50        - system clock
//            reset         - asynchronous active-low reset
//            start         - one-cycle pulse, begins init sweep from IDLE
//            audio_ready   - audio sink accepts sample this cycle
//            tap_u         - tap-column current-row value (signed)
//            row_idx       - current row
//            rd_addr_curr  - current-memory read address
//            rd_addr_prev  - previous-memory read address
//            wr_addr       - write address for both memories
//            we_curr/we_prev - memory write enables
//            init_active   - high during init sweep
//            ld_inputs     - columns latch memory read data
//            wr_strobe     - columns commit next value, shift row registers
//            first_row/last_row - row position flags
//            sample_out/sample_valid - audio sample handshake
//            step_count    - completed time steps (wraps)
//            step_cycles   - cycles of last completed step incl. stalls
// Revision : 1.0 - initial release
// ============================================================================
module drum_sweep_scheduler #(
    parameter int NUM_ROWS = 30,
    parameter int ROW_W    = 5,
    parameter int DATA_W   = 18,
    parameter int TAP_ROW  = 15
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              start,
    input  logic              audio_ready,
    input  logic [DATA_W-1:0] tap_u,
    output logic [ROW_W-1:0]  row_idx,
    output logic [ROW_W-1:0]  rd_addr_curr,
    output logic [ROW_W-1:0]  rd_addr_prev,
    output logic [ROW_W-1:0]  wr_addr,
    output logic              we_curr,
    output logic              we_prev,
    output logic              init_active,
    output logic              ld_inputs,
    output logic              wr_strobe,
    output logic              first_row,
    output logic              last_row,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic [31:0]       step_count,
    output logic [31:0]       step_cycles
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_INIT   = 3'd1;
    localparam logic [2:0] c_S_SETUP  = 3'd2;
    localparam logic [2:0] c_S_WAIT   = 3'd3;
    localparam logic [2:0] c_S_LOAD   = 3'd4;
    localparam logic [2:0] c_S_WRITE  = 3'd5;
    localparam logic [2:0] c_S_OUTPUT = 3'd6;
    localparam logic [2:0] c_S_HOLD   = 3'd7;

    localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic [ROW_W-1:0] c_TAP_ROW  = ROW_W'(TAP_ROW);

    logic [2:0]        r_state,       w_state_next;
    logic [ROW_W-1:0]  r_row,         w_row_next;
    logic [DATA_W-1:0] r_tap,         w_tap_next;
    logic [DATA_W-1:0] r_sample,      w_sample_next;
    logic              r_valid,       w_valid_next;
    logic [31:0]       r_step_count,  w_step_count_next;
    logic [31:0]       r_step_cycles, w_step_cycles_next;
    logic [31:0]       r_cycle_cnt,   w_cycle_cnt_next;
    logic              w_load;
    logic              w_last;
    logic              w_sweep;
    logic              w_rows_live;

    assign w_last = (r_row == c_LAST_ROW);

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            r_state       <= c_S_IDLE;
            r_row         <= '0;
            r_tap         <= '0;
            r_sample      <= '0;
            r_valid       <= 1'b0;
            r_step_count  <= '0;
            r_step_cycles <= '0;
            r_cycle_cnt   <= '0;
        end else begin
            r_state       <= w_state_next;
            r_row         <= w_row_next;
            r_tap         <= w_tap_next;
            r_sample      <= w_sample_next;
            r_valid       <= w_valid_next;
            r_step_count  <= w_step_count_next;
            r_step_cycles <= w_step_cycles_next;
            r_cycle_cnt   <= w_cycle_cnt_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_row_next         = r_row;
        w_tap_next         = r_tap;
        w_sample_next      = r_sample;
        w_valid_next       = r_valid;
        w_step_count_next  = r_step_count;
        w_step_cycles_next = r_step_cycles;
        w_cycle_cnt_next   = r_cycle_cnt;
        w_load             = 1'b0;

        // A transfer drops valid; a same-cycle reload below re-asserts it.
        if (r_valid && audio_ready) begin
            w_valid_next = 1'b0;
        end

        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_state_next = c_S_INIT;
                    w_row_next   = '0;
                end
            end
            c_S_INIT: begin
                if (w_last) begin
                    w_state_next = c_S_SETUP;
                    w_row_next   = '0;
                end else begin
                    w_row_next = r_row + 1'b1;
                end
            end
            c_S_SETUP: begin
                w_cycle_cnt_next = r_cycle_cnt + 32'd1;
                w_state_next     = c_S_WAIT;
            end
            c_S_WAIT: begin
                w_cycle_cnt_next = r_cycle_cnt + 32'd1;
                w_state_next     = c_S_LOAD;
            end
            c_S_LOAD: begin
                w_cycle_cnt_next = r_cycle_cnt + 32'd1;
                w_state_next     = c_S_WRITE;
            end
            c_S_WRITE: begin
                w_cycle_cnt_next = r_cycle_cnt + 32'd1;
                if (r_row == c_TAP_ROW) begin
                    w_tap_next = tap_u;
                end
                if (w_last) begin
                    w_row_next   = '0;
                    w_state_next = c_S_OUTPUT;
                end else begin
                    w_row_next   = r_row + 1'b1;
                    w_state_next = c_S_SETUP;
                end
            end
            c_S_OUTPUT: begin
                if (!r_valid || audio_ready) begin
                    w_load = 1'b1;
                end else begin
                    w_cycle_cnt_next = r_cycle_cnt + 32'd1;
                    w_state_next     = c_S_HOLD;
                end
            end
            c_S_HOLD: begin
                if (audio_ready) begin
                    w_load = 1'b1;
                end else begin
                    w_cycle_cnt_next = r_cycle_cnt + 32'd1;
                end
            end
            default: begin
                w_state_next = c_S_IDLE;
                w_row_next   = '0;
            end
        endcase

        // End-of-step hand-off; the +1 counts the hand-off cycle itself.
        if (w_load) begin
            w_sample_next      = r_tap;
            w_valid_next       = 1'b1;
            w_step_count_next  = r_step_count + 32'd1;
            w_step_cycles_next = r_cycle_cnt + 32'd1;
            w_cycle_cnt_next   = '0;
            w_row_next         = '0;
            w_state_next       = c_S_SETUP;
        end
    end

    // Read addresses stay stable through all four phases of a row so the
    // registered memory address does not change under the pending read.
    assign w_sweep     = (r_state == c_S_SETUP) || (r_state == c_S_WAIT) ||
                         (r_state == c_S_LOAD)  || (r_state == c_S_WRITE);
    assign w_rows_live = w_sweep || (r_state == c_S_INIT);

    always_comb begin
        rd_addr_curr = '0;
        if (r_state == c_S_INIT) begin
            rd_addr_curr = r_row;
        end else if (w_sweep) begin
            // Last row has no row below; hold the address.
            rd_addr_curr = w_last ? r_row : r_row + 1'b1;
        end
    end

    assign row_idx      = r_row;
    assign rd_addr_prev = w_rows_live ? r_row : '0;
    assign wr_addr      = ((r_state == c_S_INIT) || (r_state == c_S_WRITE)) ? r_row : '0;
    assign we_curr      = (r_state == c_S_INIT) || (r_state == c_S_WRITE);
    assign we_prev      = (r_state == c_S_INIT) || (r_state == c_S_WRITE);
    assign init_active  = (r_state == c_S_INIT);
    assign ld_inputs    = (r_state == c_S_LOAD);
    assign wr_strobe    = (r_state == c_S_WRITE);
    assign first_row    = w_rows_live && (r_row == '0);
    assign last_row     = w_rows_live && w_last;
    assign sample_out   = r_sample;
    assign sample_valid = r_valid;
    assign step_count   = r_step_count;
    assign step_cycles  = r_step_cycles;

endmodule
`default_nettype wire

// File: tb/tb_drum_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_drum_sweep_scheduler
// Purpose  : Directed self-checking bench for drum_sweep_scheduler: reset,
//            init sweep, row timing, tap capture, backpressure/HOLD and
//            asynchronous reset in the middle of a step.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drum_sweep_scheduler;

    logic        clk_50;
    logic        reset;
    logic        start;
    logic        audio_ready;
    logic [17:0] tap_u;
    logic [4:0]  row_idx;
    logic [4:0]  rd_addr_curr;
    logic [4:0]  rd_addr_prev;
    logic [4:0]  wr_addr;
    logic        we_curr;
    logic        we_prev;
    logic        init_active;
    logic        ld_inputs;
    logic        wr_strobe;
    logic        first_row;
    logic        last_row;
    logic [17:0] sample_out;
    logic        sample_valid;
    logic [31:0] step_count;
    logic [31:0] step_cycles;

    int checks = 0;
    int errors = 0;

    drum_sweep_scheduler #(
        .NUM_ROWS (30),
        .ROW_W    (5),
        .DATA_W   (18),
        .TAP_ROW  (15)
    ) u_dut (
        .clk_50       (clk_50),
        .reset        (reset),
        .start        (start),
        .audio_ready  (audio_ready),
        .tap_u        (tap_u),
        .row_idx      (row_idx),
        .rd_addr_curr (rd_addr_curr),
        .rd_addr_prev (rd_addr_prev),
        .wr_addr      (wr_addr),
        .we_curr      (we_curr),
        .we_prev      (we_prev),
        .init_active  (init_active),
        .ld_inputs    (ld_inputs),
        .wr_strobe    (wr_strobe),
        .first_row    (first_row),
        .last_row     (last_row),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .step_count   (step_count),
        .step_cycles  (step_cycles)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    function automatic logic [127:0] all_outs();
        return {18'd0, row_idx, rd_addr_curr, rd_addr_prev, wr_addr, we_curr,
                we_prev, init_active, ld_inputs, wr_strobe, first_row,
                last_row, sample_out, sample_valid, step_count, step_cycles};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    // Walk one full 30-row sweep starting at SETUP of row 0; returns at
    // the OUTPUT cycle. tap_val is presented only during the row-15 WRITE.
    task automatic run_step(input logic [17:0] tap_val);
        for (int r = 0; r < 30; r++) begin
            for (int p = 0; p < 4; p++) begin
                tap_u = (p == 3 && r == 15) ? tap_val : 18'h2AAAA;
                chk("row_idx",   row_idx,      r);
                chk("ld_inputs", ld_inputs,    (p == 2));
                chk("wr_strobe", wr_strobe,    (p == 3));
                chk("we_curr",   we_curr,      (p == 3));
                chk("we_prev",   we_prev,      (p == 3));
                chk("init_act",  init_active,  1'b0);
                chk("rd_prev",   rd_addr_prev, r);
                chk("rd_curr",   rd_addr_curr, (r == 29) ? 29 : r + 1);
                chk("first_row", first_row,    (r == 0));
                chk("last_row",  last_row,     (r == 29));
                if (p == 3) chk("wr_addr", wr_addr, r);
                tick();
            end
        end
        tap_u = 18'h0;
    endtask

    task automatic check_init();
        for (int i = 0; i < 30; i++) begin
            chk("init_active", init_active, 1'b1);
            chk("init_we",     {we_curr, we_prev}, 2'b11);
            chk("init_wr",     wr_addr, i);
            chk("init_rd",     {rd_addr_curr, rd_addr_prev}, {i[4:0], i[4:0]});
            tick();
        end
        chk("init_done", init_active, 1'b0);
        chk("setup_row", row_idx, 0);
        chk("setup_we",  {we_curr, we_prev}, 2'b00);
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        audio_ready = 1'b0;
        tap_u       = 18'h0;

        // Reset held with toggling inputs
        for (int i = 0; i < 3; i++) begin
            start       = i[0];
            audio_ready = ~i[0];
            tick();
            chk("reset_outs", all_outs(), 128'd0);
        end
        start       = 1'b0;
        audio_ready = 1'b0;
        reset       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_outs", all_outs(), 128'd0);
        end

        // Init sweep
        start = 1'b1;
        tick();
        start = 1'b0;
        check_init();

        // First step, sink ready
        audio_ready = 1'b1;
        run_step(18'h00400);
        chk("out1_valid", sample_valid, 1'b0);
        chk("out1_strb",  {we_curr, ld_inputs, wr_strobe}, 3'b000);
        tick();
        chk("s1_sample", sample_out,   18'h00400);
        chk("s1_valid",  sample_valid, 1'b1);
        chk("s1_count",  step_count,   32'd1);
        chk("s1_cycles", step_cycles,  32'd121);

        // Backpressure: 200 cycles of audio_ready low
        audio_ready = 1'b0;
        run_step(18'h1F000);
        chk("out2_hold_valid", sample_valid, 1'b1);
        chk("out2_sample",     sample_out,   18'h00400);
        tick();
        for (int k = 1; k < 80; k++) begin
            chk("hold_strb", {we_curr, we_prev, ld_inputs, wr_strobe, init_active},
                5'b00000);
            chk("hold_row",    row_idx,    0);
            chk("hold_sample", sample_out, 18'h00400);
            chk("hold_count",  step_count, 32'd1);
            tick();
        end
        audio_ready = 1'b1;
        tick();
        chk("s2_sample", sample_out,   18'h1F000);
        chk("s2_valid",  sample_valid, 1'b1);
        chk("s2_count",  step_count,   32'd2);
        chk("s2_cycles", step_cycles,  32'd201);
        tick();
        chk("xfer_clears_valid", sample_valid, 1'b0);
        chk("xfer_sample_kept",  sample_out,   18'h1F000);

        // Advance to row 10 WRITE (currently WAIT of row 0)
        for (int i = 0; i < 42; i++) tick();
        chk("r10_strobe", wr_strobe, 1'b1);
        chk("r10_row",    row_idx,   10);
        #2 reset = 1'b0;
        #1 chk("async_reset_outs", all_outs(), 128'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_reset_idle", all_outs(), 128'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_init();
        chk("rerun_count", step_count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
